ooo_id_responder: RTL
=====================

Name: ooo_id_responder

Overview:
Responder side of the sequential-ID request/response interface. It accepts requests tagged with unique IDs in issue order and holds each one for a pseudo-random latency. It then returns responses out of order, one per cycle, under valid/ready backpressure. It serves as the DUT-side traffic model that drives the oldest-outstanding-ID tracking logic.

Parameters:
NUM_IDS, 64, number of ID slots; equals 2**ID_W
ID_W, 6, width of req_id/resp_id
LAT_W, 4, width of the per-slot latency counter (latency 0..15)
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  request can be accepted
req_id  input  ID_W  request ID
resp_valid  output  1  response present
resp_ready  input  1  downstream takes response
resp_id  output  ID_W  ID being responded
busy_count  output  ID_W+1  pending slots plus held output (0..NUM_IDS)
err_dup  output  1  one-cycle pulse: request for an already-pending ID

Behaviour:
- Reset values: all slots pending=0, count=0; resp_valid=0, resp_id=0, busy_count=0, err_dup=0, LFSR=LFSR_SEED. req_ready is combinational and equals 1 after reset.
- req_ready = (busy_count != NUM_IDS). A request is accepted on a clock edge when req_valid && req_ready.
- Accept, slot free (pending[req_id]=0, using the pre-edge value): set pending=1 and load count = lfsr[LAT_W-1:0].
- Accept, slot pending: treat as a duplicate. Slot state is unchanged and err_dup=1 for the next cycle. busy_count is unchanged.
- Each edge, every pending slot with count>0 decrements by 1. A slot is eligible when pending && count==0, evaluated on pre-edge state.
- The output register loads when !resp_valid || resp_ready. It takes the lowest-index eligible slot, sets resp_valid=1 and resp_id=that index, and clears that slot's pending bit. If no slot is eligible, resp_valid goes to 0.
- While resp_valid && !resp_ready, resp_valid and resp_id hold stable and no slot is consumed.
- Latency: for a slot accepted on edge E0 with loaded latency L, resp_valid/resp_id appear at the earliest after edge E(L+1).
- A slot accepted on edge E0 is not eligible before E0+1. A request arriving on the same edge its own ID is being selected counts as a duplicate (the pre-edge pending bit was 1). The slot then clears and err_dup pulses.
- An ID held in the output register is not pending, so a new request for it is accepted as fresh.
- busy_count = popcount(pending) + resp_valid, maintained incrementally. Accept and completion on the same edge net to 0 change. It never exceeds NUM_IDS.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle after reset, regardless of traffic.
- Reset asserted mid-operation discards all pending slots and any held response immediately. No response is emitted afterward for pre-reset requests.

Optional Feature:
OOO_RESP_FIXED_LAT_EN
- Defined: adds input port fixed_lat [LAT_W-1:0]. Accepted slots load count = fixed_lat instead of LFSR bits. The LFSR is still present but unused for latency. Response order becomes fully deterministic, for directed tests.
- Undefined: no fixed_lat port; latency comes from the LFSR as above.

Test Plan:
- Reset: assert reset mid-traffic -> resp_valid=0, busy_count=0, err_dup=0, req_ready=1. No stale responses appear after release.
- Fixed latency (macro on), fixed_lat=2, resp_ready=1, IDs 0,1,2 accepted on E0,E1,E2 -> resp_id 0,1,2 after E3,E4,E5. busy_count peaks at 3, then returns to 0.
- Out-of-order return: ID 5 with fixed_lat=7 on E0, ID 3 with fixed_lat=0 on E1 -> resp_id=3 after E2, resp_id=5 after E8.
- Simultaneous expiry: IDs 9 and 4 reach count 0 in the same cycle -> resp_id=4 first, resp_id=9 on the next cycle.
- Backpressure and full: fixed_lat=15, resp_ready=0, IDs 0..63 on E0..E63 -> resp_id=0 held stable from E16. busy_count=64 and req_ready=0 after E63. Raising resp_ready drains 64 responses in ascending ID order.
- Duplicate: ID 7 accepted twice, 1 cycle apart -> err_dup pulses exactly one cycle, exactly one resp_id=7 is emitted, and busy_count never exceeds 1.

Source files
------------

// File: rtl/ooo_id_responder.sv
// ooo_id_responder: responder-side traffic model for the sequential-ID
// request/response interface. Requests are held per ID slot for a latency
// drawn from a 16-bit Galois LFSR. Responses are returned out of order, one
// per cycle, with the lowest eligible ID winning, under valid/ready
// backpressure.
// Optional build macro OOO_RESP_FIXED_LAT_EN: adds the fixed_lat input. When
// it is defined, every accepted slot loads fixed_lat as its latency instead of
// the LFSR bits.
module ooo_id_responder #(
  parameter int unsigned NUM_IDS   = 64,
  parameter int unsigned ID_W      = 6,
  parameter int unsigned LAT_W     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
`ifdef OOO_RESP_FIXED_LAT_EN
  input  logic [LAT_W-1:0]  fixed_lat,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [ID_W:0]     busy_count,
  output logic              err_dup
);

  logic [NUM_IDS-1:0] pending;
  logic [LAT_W-1:0]   count [NUM_IDS];
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;

  logic               accept;
  logic               fresh;
  logic               dup;
  logic               load;
  logic               take;
  logic               consume;
  logic               sel_found;
  logic [ID_W-1:0]    sel_idx;
  logic [LAT_W-1:0]   lat_load;

  assign req_ready = (busy_count != (ID_W+1)'(NUM_IDS));
  assign accept    = req_valid && req_ready;
  // Duplicate detection uses the pre-edge pending bit, so a request for the
  // ID being selected on this same edge still counts as a duplicate.
  assign fresh     = accept && !pending[req_id];
  assign dup       = accept && pending[req_id];
  assign load      = !resp_valid || resp_ready;
  assign take      = load && sel_found;
  assign consume   = resp_valid && resp_ready;

`ifdef OOO_RESP_FIXED_LAT_EN
  assign lat_load = fixed_lat;
`else
  assign lat_load = lfsr[LAT_W-1:0];
`endif

  // Galois LFSR step, x^16+x^14+x^13+x^11+1 (right-shifting form)
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsr_next = lfsr_next ^ 16'hB400;
  end

  // Lowest-index eligible slot: pending with its latency counter exhausted
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_IDS; i++) begin
      if (!sel_found && pending[i] && (count[i] == '0)) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
  end

  // LFSR free-runs from the seed whenever reset is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next;
  end

  // Slot state: a fresh accept loads the latency, the selected slot clears,
  // and every other pending slot counts down toward eligibility
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int unsigned i = 0; i < NUM_IDS; i++) count[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_IDS; i++) begin
        if (fresh && (req_id == ID_W'(i))) begin
          pending[i] <= 1'b1;
          count[i]   <= lat_load;
        end else begin
          if (take && (sel_idx == ID_W'(i))) pending[i] <= 1'b0;
          if (pending[i] && (count[i] != '0)) count[i] <= count[i] - LAT_W'(1);
        end
      end
    end
  end

  // Output register: reloads whenever empty or being taken, holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
    end else if (load) begin
      resp_valid <= sel_found;
      if (sel_found) resp_id <= sel_idx;
    end
  end

  // Occupancy: moving a slot into the output register is occupancy-neutral,
  // so only fresh accepts and downstream handshakes change the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_count <= '0;
    else       busy_count <= busy_count + (ID_W+1)'(fresh) - (ID_W+1)'(consume);
  end

  // Duplicate-request flag, one cycle per offending accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_dup <= 1'b0;
    else       err_dup <= dup;
  end

endmodule
